// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite response codes and command-master FSM states
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP
  } master_state_t;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// rtl/axi4_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a command stream
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_SIZE  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_clk_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_address_i,
  input  logic [DATA_SIZE-1:0]     cmd_data_i,
  input  logic [DATA_SIZE/8-1:0]   cmd_strb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_write_o,
  output logic [DATA_SIZE-1:0]     rsp_data_o,
  output logic [1:0]               rsp_resp_o,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_SIZE-1:0]     m_axi_wdata,
  output logic [DATA_SIZE/8-1:0]   m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_SIZE-1:0]     m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  master_state_t                 state;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [DATA_SIZE-1:0]          data_q;
  logic [DATA_SIZE/8-1:0]        strb_q;
  logic                          write_q;
  logic                          aw_done;
  logic                          w_done;
  logic [DATA_SIZE-1:0]          rsp_data_q;
  resp_t                         rsp_resp_q;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;

  assign cmd_ready_o  = (state == IDLE);
  assign rsp_write_o  = write_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_resp_o   = rsp_resp_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = data_q;
  assign m_axi_wstrb  = strb_q;

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state         <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      write_q       <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= OKAY;
      rsp_valid_o   <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i) begin
          addr_q  <= cmd_address_i;
          data_q  <= cmd_data_i;
          strb_q  <= cmd_strb_i;
          write_q <= cmd_write_i;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (cmd_write_i) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WRITE;
          end else begin
            m_axi_arvalid <= 1'b1;
            state         <= READ;
          end
        end
        // AW and W complete independently; either may finish first.
        WRITE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          rsp_resp_q   <= resp_t'(m_axi_bresp);
          rsp_data_q   <= '0;
          rsp_valid_o  <= 1'b1;
          state        <= RESP;
        end
        READ: if (ar_hs) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= RDATA;
        end
        RDATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          rsp_resp_q   <= resp_t'(m_axi_rresp);
          rsp_data_q   <= m_axi_rdata;
          rsp_valid_o  <= 1'b1;
          state        <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
